lsu_mem_access: RTL

Parametrised successor to the single-cycle LSU execute stage: a multi-cycle load/store unit with valid/ready handshakes on issue, memory and writeback sides. Supports byte, half and word accesses with byte enables, load sign/zero extension, misalign/illegal-size detection and operand forwarding. Sits between LSU issue/decode and the data-memory port; drives the LSU writeback stage.

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/lsu_align.sv | 56 +++++
 rtl/lsu_mem_access.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the multi-cycle load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_SIZE     = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } lsu_err_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } lsu_state_e;

  // Byte-enable pattern for an access of the given size at lane offset 0.
  function automatic logic [7:0] size_mask(input lsu_size_e size);
    logic [7:0] m;
    case (size)
      SZ_BYTE: m = 8'h01;
      SZ_HALF: m = 8'h03;
      SZ_WORD: m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // True when the low address bits are not a multiple of the access size.
  function automatic logic misaligned(input lsu_size_e size, input logic [2:0] ea_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = ea_lo[0];
      SZ_WORD: bad = |ea_lo[1:0];
      default: bad = |ea_lo[2:0];
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: store-data replication and byte enables on the
// way out, lane extraction and sign/zero extension on the way back.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  lsu_size_e                    size,
  input  logic                         zext,
  input  logic [$clog2(XLEN/8)-1:0]    offset,
  input  logic [XLEN-1:0]              store_data,
  output logic [XLEN/8-1:0]            be,
  output logic [XLEN-1:0]              wdata,
  input  logic [XLEN-1:0]              load_raw,
  output logic [XLEN-1:0]              load_data
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] lane;

  assign be   = NB'(size_mask(size)) << offset;
  assign lane = load_raw >> {offset, 3'b000};

  // Replicate the store operand into every lane it could land in.
  always_comb begin
    wdata = '0;
    case (size)
      SZ_BYTE: wdata = {(XLEN/8){store_data[7:0]}};
      SZ_HALF: wdata = {(XLEN/16){store_data[15:0]}};
      SZ_WORD: wdata = {(XLEN/32){store_data[31:0]}};
      default: wdata = store_data;
    endcase
  end

  // Pull the addressed lane down to bit 0 and extend it to XLEN.
  always_comb begin
    load_data = '0;
    case (size)
      SZ_BYTE: begin
        if (zext) load_data = XLEN'(lane[7:0]);
        else      load_data = XLEN'($signed(lane[7:0]));
      end
      SZ_HALF: begin
        if (zext) load_data = XLEN'(lane[15:0]);
        else      load_data = XLEN'($signed(lane[15:0]));
      end
      SZ_WORD: begin
        if (zext) load_data = XLEN'(lane[31:0]);
        else      load_data = XLEN'($signed(lane[31:0]));
      end
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Multi-cycle load/store unit: accepts one op at a time from issue, performs
// a single memory transaction and hands the result to writeback.
// Optional: define LSU_TIMEOUT_EN to bound the time spent in ISSUE+WAIT.
//
// Handshakes: every channel transfers on a cycle where valid && ready are
// both high at the rising edge. A producer holds valid and all payload
// fields stable until that edge and never drops valid early; the unit's
// own ready (req_ready) does not depend on req_valid.
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_is_load,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [4:0]          req_rd,
  input  logic [11:0]         imm,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     rs2_data,
  input  logic                is_rs1_fwd,
  input  logic                is_rs2_fwd,
  input  logic [XLEN-1:0]     rs1_fwd_data,
  input  logic [XLEN-1:0]     rs2_fwd_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rsp_valid,
  input  logic [XLEN-1:0]     mem_rsp_rdata,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [4:0]          wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                wb_is_load,
  output logic [1:0]          wb_err,
  output logic                busy
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  lsu_state_e state_q, state_d;
  lsu_err_e   err_q, err_d;

  logic [XLEN-1:0] ea_q, rs2_q, rdata_q;
  lsu_size_e       size_q;
  logic [4:0]      rd_q;
  logic            uns_q, load_q;

  logic [XLEN-1:0] rs1_op, rs2_op, ea_d;
  lsu_size_e       req_size_e;
  logic            accept, size_bad, align_bad, tmo_hit;

  logic [NB-1:0]   be_al;
  logic [XLEN-1:0] wdata_al, load_al;

  // Operand selection and effective address; the add wraps silently.
  assign rs1_op     = is_rs1_fwd ? rs1_fwd_data : rs1_data;
  assign rs2_op     = is_rs2_fwd ? rs2_fwd_data : rs2_data;
  assign ea_d       = rs1_op + XLEN'($signed(imm));
  assign req_size_e = lsu_size_e'(req_size);

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign size_bad   = (req_size_e == SZ_DWORD) && (XLEN == 32);
  assign align_bad  = misaligned(req_size_e, ea_d[2:0]);

`ifdef LSU_TIMEOUT_EN
  logic [31:0] tmo_q;

  assign tmo_hit = ((state_q == ISSUE) || (state_q == WAIT)) &&
                   (tmo_q == 32'(TIMEOUT_CYCLES - 1));

  // Count cycles spent waiting on memory; restarts with every new op.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (accept) begin
      tmo_q <= '0;
    end else if ((state_q == ISSUE) || (state_q == WAIT)) begin
      tmo_q <= tmo_q + 32'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State and error-code register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; errors detected at accept skip the memory entirely.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (size_bad) begin
            state_d = ERR;
            err_d   = ERR_SIZE;
          end else if (align_bad) begin
            state_d = ERR;
            err_d   = ERR_MISALIGN;
          end else begin
            state_d = ISSUE;
            err_d   = ERR_OK;
          end
        end
      end
      ISSUE: begin
        if (tmo_hit) begin
          state_d = RESP;
          err_d   = ERR_TIMEOUT;
        end else if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (tmo_hit) begin
          state_d = RESP;
          err_d   = ERR_TIMEOUT;
        end else if (mem_rsp_valid) begin
          state_d = RESP;
        end
      end
      RESP, ERR: begin
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the op on accept and the read data on the accepted response.
  always_ff @(posedge clk) begin
    if (rst) begin
      ea_q    <= '0;
      rs2_q   <= '0;
      rdata_q <= '0;
      size_q  <= SZ_BYTE;
      rd_q    <= '0;
      uns_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      if (accept) begin
        ea_q   <= ea_d;
        rs2_q  <= rs2_op;
        size_q <= req_size_e;
        rd_q   <= req_rd;
        uns_q  <= req_unsigned;
        load_q <= req_is_load;
      end
      if ((state_q == WAIT) && mem_rsp_valid && !tmo_hit) begin
        rdata_q <= mem_rsp_rdata;
      end
    end
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .size       (size_q),
    .zext       (uns_q),
    .offset     (ea_q[OFFW-1:0]),
    .store_data (rs2_q),
    .be         (be_al),
    .wdata      (wdata_al),
    .load_raw   (rdata_q),
    .load_data  (load_al)
  );

  // Output decode; payloads are forced to zero outside their valid states.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_be        = '0;
    mem_wdata     = '0;
    wb_valid      = 1'b0;
    wb_rd         = '0;
    wb_data       = '0;
    wb_is_load    = 1'b0;
    wb_err        = ERR_OK;
    if (state_q == ISSUE) begin
      mem_req_valid = 1'b1;
      mem_we        = !load_q;
      mem_addr      = {ea_q[XLEN-1:OFFW], {OFFW{1'b0}}};
      mem_be        = be_al;
      mem_wdata     = wdata_al;
    end
    if ((state_q == RESP) || (state_q == ERR)) begin
      wb_valid   = 1'b1;
      wb_rd      = rd_q;
      wb_is_load = load_q;
      wb_err     = err_q;
      if ((state_q == RESP) && (err_q == ERR_OK) && load_q) wb_data = load_al;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
